// File: rtl/bit_serial_subtractor.sv
// Bit-serial A - B - Bin: one full-subtractor cell plus a borrow flop, LSB first.
// Define SIGNED_OVF_EN to add a registered two's-complement overflow flag (ovf).
module bit_serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic [WIDTH-1:0] S,
    output logic             Bout,
    output logic             busy,
`ifdef SIGNED_OVF_EN
    output logic             ovf,
`endif
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] diff_sr;
    logic [WIDTH-1:0] diff_next;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             d;
    logic             br_next;
    logic             accept;
    logic             last;
`ifdef SIGNED_OVF_EN
    logic             a_msb;
    logic             b_msb;
`endif

    assign accept    = load && (state != SHIFT);
    assign last      = (cnt == CW'(WIDTH - 1));
    assign d         = a_sr[0] ^ b_sr[0] ^ br;
    assign br_next   = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
    // Newest difference bit enters at the top; after WIDTH steps bit 0 sits at the LSB.
    assign diff_next = {d, diff_sr};

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (load) state_next = SHIFT;
            SHIFT:   if (last) state_next = DONE;
            DONE:    state_next = load ? SHIFT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr    <= '0;
            b_sr    <= '0;
            diff_sr <= '0;
            cnt     <= '0;
            br      <= 1'b0;
            S       <= '0;
            Bout    <= 1'b0;
`ifdef SIGNED_OVF_EN
            a_msb   <= 1'b0;
            b_msb   <= 1'b0;
            ovf     <= 1'b0;
`endif
        end else if (accept) begin
            a_sr    <= A;
            b_sr    <= B;
            br      <= Bin;
            diff_sr <= '0;
            cnt     <= '0;
`ifdef SIGNED_OVF_EN
            a_msb   <= A[WIDTH-1];
            b_msb   <= B[WIDTH-1];
`endif
        end else if (state == SHIFT) begin
            a_sr    <= a_sr >> 1;
            b_sr    <= b_sr >> 1;
            br      <= br_next;
            diff_sr <= diff_next[WIDTH-1:1];
            cnt     <= cnt + CW'(1);
            if (last) begin
                S    <= diff_next;
                Bout <= br_next;
`ifdef SIGNED_OVF_EN
                ovf  <= (a_msb != b_msb) && (d != a_msb);
`endif
            end
        end
    end

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Directed-vector bench for bit_serial_subtractor (WIDTH=8).
// Checks ovf as well when built with SIGNED_OVF_EN.
module tb_bit_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             load;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic [WIDTH-1:0] S;
    logic             Bout;
    logic             busy;
    logic             done;
`ifdef SIGNED_OVF_EN
    logic             ovf;
`endif

    bit_serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .A    (A),
        .B    (B),
        .Bin  (Bin),
        .S    (S),
        .Bout (Bout),
        .busy (busy),
`ifdef SIGNED_OVF_EN
        .ovf  (ovf),
`endif
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] s;
        logic       bout;
        logic       ovf;
    } vec_t;

    vec_t vecs[11];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Called at a negedge; returns one negedge after the accepting edge.
    task automatic apply_load(input logic [7:0] a, input logic [7:0] b,
                              input logic bin);
        A    = a;
        B    = b;
        Bin  = bin;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    // n counts posedges since (and including) the accepting edge.
    task automatic wait_done(input int start, output int n);
        n = start;
        while (!done && n <= 20) begin
            if (!busy) begin
                total_cnt++;
                $display("FAIL busy_low: busy=0 at edge %0d before done", n);
            end
            @(negedge clk);
            n++;
        end
        check("done_seen", done, 1'b1);
        check("busy_with_done", busy, 1'b0);
    endtask

    initial begin
        int n;
        bit saw_done;

        vecs[0]  = '{8'h14, 8'h0E, 1'b0, 8'h06, 1'b0, 1'b0};
        vecs[1]  = '{8'h0E, 8'h14, 1'b0, 8'hFA, 1'b1, 1'b0};
        vecs[2]  = '{8'h06, 8'h06, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[3]  = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[4]  = '{8'hFF, 8'h01, 1'b0, 8'hFE, 1'b0, 1'b0};
        vecs[5]  = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
        vecs[6]  = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[7]  = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[8]  = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[9]  = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
        vecs[10] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};

        rst  = 1'b1;
        load = 1'b0;
        A    = '0;
        B    = '0;
        Bin  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_S", S, 8'h00);
        check("rst_Bout", Bout, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
`ifdef SIGNED_OVF_EN
        check("rst_ovf", ovf, 1'b0);
`endif

        for (int i = 0; i < 11; i++) begin
            apply_load(vecs[i].a, vecs[i].b, vecs[i].bin);
            check($sformatf("v%0d_busy", i), busy, 1'b1);
            wait_done(1, n);
            check($sformatf("v%0d_latency", i), n, WIDTH + 1);
            check($sformatf("v%0d_S", i), S, vecs[i].s);
            check($sformatf("v%0d_Bout", i), Bout, vecs[i].bout);
`ifdef SIGNED_OVF_EN
            check($sformatf("v%0d_ovf", i), ovf, vecs[i].ovf);
`endif
            @(negedge clk);
            check($sformatf("v%0d_done_clr", i), done, 1'b0);
            check($sformatf("v%0d_S_hold", i), S, vecs[i].s);
        end

        // Load during busy is ignored.
        apply_load(8'h14, 8'h0E, 1'b0);
        @(negedge clk);
        @(negedge clk);
        A    = 8'hFF;
        B    = 8'h01;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_done(4, n);
        check("ign_latency", n, WIDTH + 1);
        check("ign_S", S, 8'h06);
        check("ign_Bout", Bout, 1'b0);

        // Load on the done cycle is accepted.
        apply_load(8'h05, 8'h03, 1'b0);
        check("b2b_busy", busy, 1'b1);
        check("b2b_done", done, 1'b0);
        wait_done(1, n);
        check("b2b_latency", n, WIDTH + 1);
        check("b2b_S", S, 8'h02);
        check("b2b_Bout", Bout, 1'b0);
        @(negedge clk);

        // Reset mid-operation aborts without a done pulse.
        apply_load(8'h55, 8'h11, 1'b0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("abort_busy_pre", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_S", S, 8'h00);
        check("abort_Bout", Bout, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        saw_done = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check("abort_no_done", saw_done, 1'b0);

        // Load together with reset is not accepted.
        rst  = 1'b1;
        A    = 8'h14;
        B    = 8'h0E;
        load = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        load = 1'b0;
        check("rstld_busy", busy, 1'b0);
        @(negedge clk);
        check("rstld_busy2", busy, 1'b0);
        check("rstld_done", done, 1'b0);
        check("rstld_S", S, 8'h00);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
